// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with round-robin or fixed select, packet-locked grant and a registered output.
module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, cur, grant;
  logic grant_ok, can_load, acc;
  assign can_load = !out_valid || out_ready;
  // Descending scan so the last hit wins: that is the first valid channel after ptr.
  always_comb begin
    grant = '0;
    grant_ok = 1'b0;
    if (state == LOCKED) begin
      grant = cur;
      grant_ok = 1'b1;
    end else if (mode) begin
      grant = sel;
      grant_ok = (int'(sel) < N_CH) && in_valid[sel];
    end else begin
      for (int i = N_CH; i >= 1; i--) begin
        if (in_valid[(int'(ptr) + i) % N_CH]) begin
          grant = SEL_W'((int'(ptr) + i) % N_CH);
          grant_ok = 1'b1;
        end
      end
    end
  end
  always_comb begin
    in_ready = '0;
    if (!rst && can_load && grant_ok) in_ready[grant] = 1'b1;
  end
  assign acc = in_valid[grant] && in_ready[grant];
  always_comb begin
    state_n = state;
    if (acc) state_n = in_last[grant] ? IDLE : LOCKED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= SEL_W'(N_CH - 1);
      cur <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        out_valid <= 1'b1;
        out_data <= in_data[int'(grant)*DATA_W +: DATA_W];
        out_last <= in_last[grant];
        out_ch <= grant;
        cur <= grant;
        if (state == IDLE) ptr <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and randomized checks of stream_mux_rr against a behavioural arbitration model.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SW = 2;
  logic clk = 0, rst = 1, mode = 0, out_ready = 0;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0, in_last = '0;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic out_last, out_valid;
  logic [SW-1:0] out_ch;
  int checks = 0, failures = 0;
  bit m_ov, m_ol, m_lock, m_acc;
  int m_od, m_oc, m_cur, m_ptr, m_g;
  always #5 clk = ~clk;
  stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ov = 0; m_ol = 0; m_od = 0; m_oc = 0;
    m_lock = 0; m_cur = 0; m_ptr = N - 1; m_acc = 0; m_g = 0;
  endtask
  // Called at a falling edge with inputs already applied; ends at the next falling edge.
  task automatic step();
    bit can, gok;
    int exp_rdy;
    #1;
    can = !m_ov || out_ready;
    gok = 0;
    m_g = 0;
    if (m_lock) begin
      m_g = m_cur; gok = 1;
    end else if (mode) begin
      m_g = int'(sel); gok = in_valid[sel];
    end else begin
      for (int j = 1; j <= N; j++)
        if (!gok && in_valid[(m_ptr + j) % N]) begin m_g = (m_ptr + j) % N; gok = 1; end
    end
    exp_rdy = (can && gok) ? (1 << m_g) : 0;
    check("in_ready", in_ready, exp_rdy);
    m_acc = can && gok && in_valid[m_g];
    @(posedge clk);
    if (m_acc) begin
      m_ov = 1; m_od = int'(in_data[m_g*W +: W]); m_ol = in_last[m_g]; m_oc = m_g;
      if (!m_lock) m_ptr = m_g;
      m_lock = !in_last[m_g];
      m_cur = m_g;
    end else if (out_ready) m_ov = 0;
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_last", out_last, m_ol);
      check("out_ch", out_ch, m_oc);
    end
  endtask
  // Producers hold a beat until the model says it was taken, then maybe offer a new one.
  task automatic rand_inputs();
    for (int k = 0; k < N; k++) begin
      if (!in_valid[k] || (m_acc && m_g == k)) begin
        in_valid[k] = ($urandom_range(0, 2) != 0);
        in_data[k*W +: W] = W'($urandom);
        in_last[k] = ($urandom_range(0, 2) == 0);
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
    mode = ($urandom_range(0, 3) == 0);
    sel = SW'($urandom_range(0, N - 1));
  endtask
  initial begin
    model_reset();
    in_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    @(negedge clk);
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    in_last = 4'hF;
    out_ready = 1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_ch", out_ch, i % 4);
      check("rr_data", out_data, 'h10 + i % 4);
    end
    in_valid = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 4'b0100 : 4'b0000;
      in_data[2*W +: W] = W'('hA0 + b);
      step();
      check("lock_ch", out_ch, 2);
      check("lock_data", out_data, 'hA0 + b);
    end
    in_valid = 4'b0011; in_last = 4'b0011;
    step();
    check("after_lock_ch0", out_ch, 0);
    in_valid = 4'b0010;
    step();
    check("after_lock_ch1", out_ch, 1);
    mode = 1; sel = 3;
    in_valid = 4'b1010; in_last = 4'b0010;
    step();
    check("fixed_ch3_a", out_ch, 3);
    sel = 1; in_last = 4'b1010;
    step();
    check("fixed_ch3_b", out_ch, 3);
    in_valid = 4'b0010;
    step();
    check("fixed_ch1", out_ch, 1);
    sel = 0;
    step();
    check("fixed_invalid_sel", out_valid, 0);
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end
    rst = 1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 0; mode = 0; out_ready = 1;
    in_valid = 4'b0010; in_last = 4'b0000;
    step();
    check("mid_lock_ch1", out_ch, 1);
    step();
    #2 rst = 1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    in_valid = 4'b0110; in_last = 4'b0110;
    step();
    check("post_rst_ch", out_ch, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel successor to the team's 4-to-1 combinational multiplexer.
- Selects one of N_CH valid/ready input streams and forwards it to one registered output stream.
- Two modes: round-robin arbitration or fixed software select.
- Grant is locked for a whole packet, from the first beat to the beat with last set.
- Sits between channel producers and a single shared downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel.
- SEL_W (localparam, not overridable), max(1, clog2(N_CH)), channel index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel to serve when mode=1.
- in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  N_CH  per-channel valid.
- in_last  input  N_CH  per-channel end-of-packet flag.
- in_ready  output  N_CH  per-channel ready; at most one bit high.
- out_data  output  DATA_W  registered data.
- out_last  output  1  registered end-of-packet flag.
- out_ch  output  SEL_W  source channel of the current output beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1): out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr pointer=N_CH-1 (first round-robin grant is ch0).
- in_ready is forced to all-zero while rst=1.
- Output register, single entry. can_load = !out_valid || out_ready.
- in_ready[k] = can_load && (grant == k) && grant exists.
- Beat on channel k is accepted at a rising edge when in_valid[k] && in_ready[k].
- Accepted beat is loaded into out_data, out_last and out_ch=k, with out_valid=1, visible after the same edge (latency 1 cycle).
- Throughput is 1 beat/cycle with out_ready held high.
- If out_valid && out_ready and no beat is accepted that edge, out_valid goes to 0.
- While out_valid && !out_ready: out_data, out_last and out_ch hold stable, and in_ready is all zero.
- State IDLE, round-robin (mode=0): grant = first k with in_valid[k], searching from (ptr+1) mod N_CH upward with wrap-around.
- State IDLE, fixed (mode=1): grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
- mode and sel are sampled only in IDLE.
- On an accepted beat in IDLE: ptr <- grant.
  - If in_last=0: go to LOCKED with cur=grant.
  - If in_last=1: stay in IDLE (single-beat packet).
- State LOCKED: grant = cur regardless of mode, sel or other channels' valid; other channels stall.
- In LOCKED, an accepted beat with in_last=1 returns the block to IDLE.
- In LOCKED, in_valid[cur]=0 produces a bubble and does not release the lock.
- Changes to mode or sel during LOCKED have no effect until the packet ends.
- No combinational path from in_data to in_ready.
- Reset mid-packet: the partial packet is dropped and all state returns to reset values asynchronously; there is no recovery of dropped beats.
- No beat is ever duplicated or lost outside reset.

Test Plan:
- Reset: rst=1 with in_valid=4'hF -> in_ready=0 and out_valid=0. Release rst, out_ready=1 -> first output out_ch=0.
- Round-robin fairness: all channels valid, in_last=1, in_data ch k = 8'h10+k, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles and out_data 10,11,12,13,10,11.
- Packet lock: ch2 sends 3 beats A0,A1,A2 (last on A2) while ch0 and ch1 are valid and ch3 is idle -> out_ch 2,2,2, then 0, then 1; in_ready[0] stays 0 during the packet.
- Backpressure: drop out_ready for 3 cycles while out_valid=1 -> out_data, out_ch and out_last are stable, in_ready=0. Restore -> the remaining beats arrive in order, none lost or duplicated.
- Fixed mode: mode=1, sel=3, ch1 and ch3 valid -> only ch3 is served. Change sel to 1 during ch3's 2-beat packet -> ch3 completes, then ch1 is served. sel pointing at an invalid channel -> out_valid=0.
- Reset mid-packet: assert rst while LOCKED on ch1 -> out_valid=0 immediately without a clock edge. After release with ch1 and ch2 valid -> grant goes to ch0 if valid, else ch1 (pointer was reset).
